// File: rtl/bram_loader.sv
// bram_loader: fills a single-port block RAM from a byte stream or with a
// constant, then reads the written range back and compares checksums.
// Port A of the RAM is driven directly; consumers read only after done.
module bram_loader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_val,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       checksum
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    // Marks the tag stage whose data is on bram_dout this cycle.
    localparam logic [RD_LAT-1:0] TAG_LAST = RD_LAT'(1) << (RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LOAD,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [CNT_W-1:0]  n_q,     n_d;
    logic [DATA_W-1:0] fill_q,  fill_d;
    logic [15:0]       wsum_q,  wsum_d;
    logic [15:0]       rsum_q,  rsum_d;
    logic              err_q,   err_d;
    logic [RD_LAT-1:0] tag_q,   tag_d;

    logic              addr_last;
    logic [CNT_W-1:0]  len_n;
    logic [15:0]       rsum_inc;
    logic              early_pending;

    assign addr_last     = ({1'b0, addr_q} + CNT_W'(1)) == n_q;
    assign len_n         = (len > DEPTH_C) ? DEPTH_C : len;
    assign rsum_inc      = rsum_q + ((|(tag_q & TAG_LAST)) ? 16'(bram_dout) : 16'd0);
    assign early_pending = |(tag_q & ~TAG_LAST);

    assign err      = err_q;
    assign checksum = wsum_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            n_q     <= '0;
            fill_q  <= '0;
            wsum_q  <= '0;
            rsum_q  <= '0;
            err_q   <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            fill_q  <= fill_d;
            wsum_q  <= wsum_d;
            rsum_q  <= rsum_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
        end
    end

    // Next-state, counters, sums and RAM/handshake outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        n_d       = n_q;
        fill_d    = fill_q;
        wsum_d    = wsum_q;
        rsum_d    = rsum_inc;
        err_d     = err_q;
        tag_d     = tag_q << 1;
        s_ready   = 1'b0;
        bram_we   = 1'b0;
        bram_din  = '0;
        bram_addr = addr_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fill_d = fill_val;
                    wsum_d = '0;
                    rsum_d = '0;
                    err_d  = 1'b0;
                    addr_d = '0;
                    n_d    = clear ? DEPTH_C : len_n;
                    // An empty load passes through DRAIN with nothing in flight.
                    if (!clear && len_n == '0) begin
                        state_d = S_DRAIN;
                    end else if (clear) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_FILL: begin
                busy     = 1'b1;
                bram_we  = 1'b1;
                bram_din = fill_q;
                wsum_d   = wsum_q + 16'(fill_q);
                if (addr_last) begin
                    addr_d  = '0;
                    state_d = S_VERIFY;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            S_LOAD: begin
                busy     = 1'b1;
                s_ready  = 1'b1;
                bram_din = s_data;
                if (s_valid) begin
                    bram_we = 1'b1;
                    wsum_d  = wsum_q + 16'(s_data);
                    if (addr_last) begin
                        addr_d  = '0;
                        state_d = S_VERIFY;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end

            S_VERIFY: begin
                busy  = 1'b1;
                tag_d = (tag_q << 1) | RD_LAT'(1);
                if (addr_last) begin
                    addr_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            S_DRAIN: begin
                busy = 1'b1;
                // The final return is folded in on the same edge that decides err.
                if (!early_pending) begin
                    err_d   = (rsum_inc != wsum_q);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bram_loader.sv
// Testbench for bram_loader: table of operations applied in a loop with a
// write scoreboard, a behavioural RAM with optional readback corruption,
// and hand-written sequences for reset mid-load and sticky err.
module tb_bram_loader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned RD_LAT = 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              clear;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] fill_val;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_we;
    logic [DATA_W-1:0] bram_dout;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       checksum;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bram_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .len       (len),
        .fill_val  (fill_val),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_we   (bram_we),
        .bram_dout (bram_dout),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM, one cycle read latency.
    logic [DATA_W-1:0] mem [DEPTH];
    logic              corrupt;
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr] ^ ((corrupt && bram_addr == ADDR_W'(2)) ? 8'h01 : 8'h00);
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Write scoreboard: expected writes queued when stimulus is set up.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;
    wr_t wq[$];
    wr_t mon_e;

    always @(negedge clk) begin
        if (rst_n && bram_we) begin
            if (wq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_write: got write addr %0h data %0h, expected no write", bram_addr, bram_din);
            end else begin
                mon_e = wq.pop_front();
                check("wr_addr", 32'(bram_addr), 32'(mon_e.a));
                check("wr_data", 32'(bram_din), 32'(mon_e.d));
            end
        end
    end

    typedef struct {
        logic        clear;
        logic [9:0]  len;
        logic [7:0]  fill;
        int          cmode;   // 0: bytes from d, 1: constant cval, 2: ramp i[7:0]
        logic [7:0]  cval;
        logic [31:0] d;
        int          gap;
        logic        corrupt;
        logic        poke;
        logic [15:0] exp_cs;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [7:0] word_of(input vec_t v, input int i);
        logic [31:0] dd;
        dd = v.d;
        case (v.cmode)
            0:       return dd[8*i +: 8];
            1:       return v.cval;
            default: return i[7:0];
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},   32'(s_ready),   0);
        check({tag, "_bram_we"},   32'(bram_we),   0);
        check({tag, "_bram_addr"}, 32'(bram_addr), 0);
        check({tag, "_bram_din"},  32'(bram_din),  0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_done"},      32'(done),      0);
        check({tag, "_err"},       32'(err),       0);
        check({tag, "_checksum"},  32'(checksum),  0);
    endtask

    task automatic run_op(input vec_t v);
        int n;
        int t0;
        int lat;
        bit op_done;
        wr_t e;
        n = v.clear ? DEPTH : ((int'(v.len) > DEPTH) ? DEPTH : int'(v.len));
        for (int i = 0; i < n; i++) begin
            e.a = i[ADDR_W-1:0];
            e.d = v.clear ? v.fill : word_of(v, i);
            wq.push_back(e);
        end
        corrupt = v.corrupt;
        op_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; clear = v.clear; len = v.len; fill_val = v.fill;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        fork
            begin : sender
                if (!v.clear && n > 0) begin
                    for (int i = 0; i < n; i++) begin
                        bit acc;
                        s_data  = word_of(v, i);
                        s_valid = 1'b1;
                        acc = 1'b0;
                        for (int k = 0; k < 200 && !acc; k++) begin
                            @(negedge clk);
                            acc = s_ready;
                            @(posedge clk); #1;
                        end
                        if (!acc) begin
                            tests++;
                            fails++;
                            $display("FAIL accept_timeout: word %0d not accepted, expected acceptance", i);
                            break;
                        end
                        if (i == n - 1) begin
                            s_data = 8'h77;
                            @(negedge clk);
                            check("ready_drop", 32'(s_ready), 0);
                        end else if (v.gap > 0) begin
                            s_valid = 1'b0;
                            repeat (v.gap) @(posedge clk);
                            #1;
                        end
                    end
                    // Keep offering words: none may be accepted beyond N.
                    s_valid = 1'b1;
                    s_data  = 8'h77;
                    while (!op_done) @(posedge clk);
                    #1 s_valid = 1'b0;
                end
            end
            begin : poker
                if (v.poke) begin
                    repeat (3) @(posedge clk);
                    #1;
                    start = 1'b1; clear = 1'b1; len = 10'd1; fill_val = 8'h55;
                    @(posedge clk); #1;
                    start = 1'b0; clear = v.clear; len = v.len; fill_val = v.fill;
                end
            end
            begin : waiter
                @(negedge clk);
                check("start_busy",   32'(busy),     1);
                check("start_err_clr", 32'(err),     0);
                check("start_cs_clr", 32'(checksum), 0);
                lat = -1;
                for (int k = 0; k < 5000; k++) begin
                    if (done) begin
                        lat = cyc - t0;
                        break;
                    end
                    @(negedge clk);
                end
                if (lat < 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_timeout: got no done, expected done after %0d cycles", v.exp_lat);
                end else begin
                    check("latency",     32'(lat),       32'(v.exp_lat));
                    check("busy_at_done", 32'(busy),     0);
                    check("checksum",    32'(checksum),  32'(v.exp_cs));
                    check("err",         32'(err),       32'(v.exp_err));
                    check("writes_left", 32'(wq.size()), 0);
                    @(negedge clk);
                    check("done_pulse",  32'(done),      0);
                    check("cs_hold",     32'(checksum),  32'(v.exp_cs));
                    check("err_hold",    32'(err),       32'(v.exp_err));
                end
                op_done = 1'b1;
            end
        join
        wq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // clear len fill cmode cval d gap corrupt poke exp_cs exp_err exp_lat
        vecs[0] = '{1'b1, 10'd0,   8'hA5, 0, 8'h00, 32'h0,         0, 1'b0, 1'b0, 16'h4A00, 1'b0, 1026};
        vecs[1] = '{1'b0, 10'd4,   8'h00, 0, 8'h00, 32'hFF030201,  2, 1'b0, 1'b0, 16'h0105, 1'b0, 16};
        vecs[2] = '{1'b0, 10'd300, 8'h00, 1, 8'hFF, 32'h0,         0, 1'b0, 1'b0, 16'h2AD4, 1'b0, 602};
        vecs[3] = '{1'b0, 10'd0,   8'h00, 0, 8'h00, 32'h0,         0, 1'b0, 1'b0, 16'h0000, 1'b0, 2};
        vecs[4] = '{1'b0, 10'd600, 8'h00, 2, 8'h00, 32'h0,         0, 1'b0, 1'b0, 16'hFF00, 1'b0, 1026};
        vecs[5] = '{1'b0, 10'd4,   8'h00, 0, 8'h00, 32'hFF030201,  2, 1'b0, 1'b1, 16'h0105, 1'b0, 16};
        vecs[6] = '{1'b0, 10'd4,   8'h00, 0, 8'h00, 32'hFF030201,  0, 1'b1, 1'b0, 16'h0105, 1'b1, 10};

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; len = '0; fill_val = '0;
        s_data = '0; s_valid = 1'b0; corrupt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // err stays set after a corrupted verify until the next start.
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(err), 1);
        v = vecs[3];
        run_op(v);

        // Reset in the middle of a stream load.
        corrupt = 1'b0;
        wq.push_back('{a: ADDR_W'(0), d: 8'h11});
        wq.push_back('{a: ADDR_W'(1), d: 8'h22});
        wq.push_back('{a: ADDR_W'(2), d: 8'h33});
        @(posedge clk); #1;
        start = 1'b1; clear = 1'b0; len = 10'd8;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1; s_data = 8'h11;
        @(posedge clk); #1 s_data = 8'h22;
        @(posedge clk); #1 s_data = 8'h33;
        @(posedge clk); #1 s_valid = 1'b0;
        check("mid_busy", 32'(busy), 1);
        check("mid_cs", 32'(checksum), 32'h66);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        check("rst_writes_left", 32'(wq.size()), 0);
        wq.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        v = vecs[6];
        v.corrupt = 1'b0;
        v.exp_err = 1'b0;
        run_op(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
